trng_seed_fetcher: RTL

// - Bus initiator for the TRNG core register interface (cs/we/address/write_data -> read_data/ready).
// - On request: identifies the core, optionally programs its sample rate, then polls STATUS.
// - Reads NUM_WORDS entropy words and presents them as one seed vector with a valid flag.
// - Sits between the TRNG core and a seed consumer, e.g. a DRBG reseed port.

---
 rtl/trng_bus_pkg.sv | 26 ++
 rtl/trng_bus_if.sv | 12 +
 rtl/trng_bus_xact.sv | 64 ++++++
 rtl/trng_seed_fetcher.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/trng_bus_pkg.sv
// Shared definitions for the TRNG seed fetcher: core register map,
// identification constant, status bit position and fetch FSM encoding.
package trng_bus_pkg;

  localparam logic [7:0]  ADDR_NAME0       = 8'h00;
  localparam logic [7:0]  ADDR_NAME1       = 8'h01;
  localparam logic [7:0]  ADDR_VERSION     = 8'h02;
  localparam logic [7:0]  ADDR_STATUS      = 8'h09;
  localparam logic [7:0]  ADDR_SAMPLE_RATE = 8'h10;
  localparam logic [7:0]  ADDR_ENTROPY     = 8'h20;

  localparam logic [31:0] CORE_NAME0       = 32'h66696761;
  localparam int          STATUS_READY_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IDENT,
    ST_CFG,
    ST_POLL,
    ST_GAP,
    ST_FETCH,
    ST_DONE,
    ST_ERR
  } fetch_state_t;

endpackage

// File: rtl/trng_bus_if.sv
// Register bus between the seed fetcher (master) and the TRNG core (slave).
interface trng_bus_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output cs, we, address, write_data, input read_data, ready);
  modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/trng_bus_xact.sv
// Single-access bus engine: launches one access on req, holds the bus
// stable until ready, and aborts after XACT_TMO waiting cycles.
// done/rdata/timeout are valid in the cycle of the closing edge.
module trng_bus_xact #(
  parameter int XACT_TMO = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout,
  trng_bus_if.master  bus
);

  localparam int             TW       = (XACT_TMO > 1) ? $clog2(XACT_TMO + 1) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(XACT_TMO - 1);

  logic          r_cs;
  logic          r_we;
  logic [7:0]    r_addr;
  logic [31:0]   r_wdata;
  logic [TW-1:0] r_tmo;
  logic          w_wait;

  // ready wins over a timeout that would fire in the same cycle
  assign done    = r_cs & bus.ready;
  assign w_wait  = r_cs & ~bus.ready;
  assign timeout = w_wait & (r_tmo == TMO_LAST);
  assign rdata   = bus.read_data;

  assign bus.cs         = r_cs;
  assign bus.we         = r_we;
  assign bus.address    = r_addr;
  assign bus.write_data = r_wdata;

  // access launch, hold until handshake or timeout, then release cs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 32'h0;
      r_tmo   <= '0;
    end else if (r_cs) begin
      if (done || timeout) begin
        r_cs  <= 1'b0;
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end else if (req) begin
      r_cs    <= 1'b1;
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_tmo   <= '0;
    end
  end

endmodule

// File: rtl/trng_seed_fetcher.sv
// Seed fetcher: identifies the TRNG core, optionally programs its sample
// rate (build with TRNG_FETCH_RATE_EN), polls STATUS before every word and
// collects NUM_WORDS entropy words into one seed vector.
module trng_seed_fetcher
  import trng_bus_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int POLL_GAP  = 4,
  parameter int XACT_TMO  = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [23:0]            sample_rate,
  output logic                   busy,
  output logic [32*NUM_WORDS-1:0] seed,
  output logic                   seed_valid,
  output logic                   error,
  trng_bus_if.master             bus
);

  localparam int            CW       = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] LAST     = CW'(NUM_WORDS - 1);
  localparam int            GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  fetch_state_t  r_state, w_state_next;
  logic [CW-1:0] r_count;
  logic [GW-1:0] r_gap;

  logic          w_req, w_we, w_done, w_timeout, w_start_ok, w_word_we;
  logic [7:0]    w_addr;
  logic [31:0]   w_wdata, w_rdata;
  logic          w_unused_rate;

  assign w_unused_rate = ^sample_rate;

  trng_bus_xact #(.XACT_TMO(XACT_TMO)) u_xact (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_req),
    .we      (w_we),
    .addr    (w_addr),
    .wdata   (w_wdata),
    .done    (w_done),
    .rdata   (w_rdata),
    .timeout (w_timeout),
    .bus     (bus)
  );

  // next state and bus request; the last GAP cycle launches the next poll
  // so exactly POLL_GAP idle cycles separate failed polls
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = ADDR_NAME0;
    w_wdata      = 32'h0;
    w_start_ok   = 1'b0;
    w_word_we    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_next = ST_IDENT;
          w_start_ok   = 1'b1;
        end
      end
      ST_IDENT: begin
        w_req  = 1'b1;
        w_addr = ADDR_NAME0;
        if (w_timeout) w_state_next = ST_ERR;
        else if (w_done) begin
`ifdef TRNG_FETCH_RATE_EN
          w_state_next = (w_rdata == CORE_NAME0) ? ST_CFG : ST_ERR;
`else
          w_state_next = (w_rdata == CORE_NAME0) ? ST_POLL : ST_ERR;
`endif
        end
      end
`ifdef TRNG_FETCH_RATE_EN
      ST_CFG: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = ADDR_SAMPLE_RATE;
        w_wdata = {8'h00, sample_rate};
        if (w_timeout) w_state_next = ST_ERR;
        else if (w_done) w_state_next = ST_POLL;
      end
`endif
      ST_POLL: begin
        w_req  = 1'b1;
        w_addr = ADDR_STATUS;
        if (w_timeout) w_state_next = ST_ERR;
        else if (w_done) begin
          if (w_rdata[STATUS_READY_BIT]) w_state_next = ST_FETCH;
          else w_state_next = (POLL_GAP == 0) ? ST_POLL : ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_next = ST_POLL;
          w_req        = 1'b1;
          w_addr       = ADDR_STATUS;
        end
      end
      ST_FETCH: begin
        w_req  = 1'b1;
        w_addr = ADDR_ENTROPY;
        if (w_timeout) w_state_next = ST_ERR;
        else if (w_done) begin
          w_word_we    = 1'b1;
          w_state_next = (r_count == LAST) ? ST_DONE : ST_POLL;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // word counter; DONE is taken before it could pass NUM_WORDS
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_count <= '0;
    else if (w_start_ok) r_count <= '0;
    else if (w_word_we)  r_count <= r_count + CW'(1);
  end

  // idle-cycle counter between failed STATUS polls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_gap <= '0;
    else if (r_state == ST_GAP && r_gap != GAP_LAST) r_gap <= r_gap + GW'(1);
    else                                           r_gap <= '0;
  end

  // one register per seed word, written only by its own FETCH handshake
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    logic [31:0] r_word;
    // capture entropy word gi, clear on an accepted start
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                               r_word <= 32'h0;
      else if (w_start_ok)                        r_word <= 32'h0;
      else if (w_word_we && r_count == CW'(gi))   r_word <= w_rdata;
    end
    assign seed[32*gi +: 32] = r_word;
  end

  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
  assign seed_valid = (r_state == ST_DONE);
  assign error      = (r_state == ST_ERR);

endmodule
